// File: rtl/controle_cofre_if.sv
// User-side bus of the safe controller: attempt/close/program strobes in, LED and status flags out.
interface controle_cofre_if;
    logic [3:0] tentativa;
    logic       confirmar;
    logic       fechar;
    logic       gravar;
    logic [3:0] senha_nova;
    logic       aberto;
    logic       perto;
    logic       errado;
    logic       bloqueado;
    logic [2:0] falhas;

    modport master (
        output tentativa, confirmar, fechar, gravar, senha_nova,
        input  aberto, perto, errado, bloqueado, falhas
    );

    modport slave (
        input  tentativa, confirmar, fechar, gravar, senha_nova,
        output aberto, perto, errado, bloqueado, falhas
    );
endinterface

// File: rtl/controle_cofre.sv
// Safe controller: password check, timed opening, failure counting and timed lockout.
// Define SENHA_PROGRAMAVEL_EN to allow loading a new password while the safe is open.
module controle_cofre #(
    parameter logic [3:0]  SENHA_PADRAO   = 4'd0,
    parameter int unsigned MAX_TENTATIVAS = 3,
    parameter int unsigned TEMPO_ABERTO   = 8,
    parameter int unsigned TEMPO_BLOQUEIO = 16
) (
    input logic             clock,
    input logic             reset,
    controle_cofre_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ABERTO    = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

    localparam logic [7:0] TIMER_ABERTO_INI   = 8'(TEMPO_ABERTO - 1);
    localparam logic [7:0] TIMER_BLOQUEIO_INI = 8'(TEMPO_BLOQUEIO - 1);
    localparam logic [2:0] LIMITE_FALHAS      = 3'(MAX_TENTATIVAS);

    estado_t    state_r;
    logic [7:0] timer_r;
    logic [2:0] falhas_r;
    logic       aberto_r;
    logic       perto_r;
    logic       errado_r;
    logic       bloqueado_r;
    logic [3:0] senha_s;
    logic [3:0] diff_s;
    logic [2:0] falhas_inc_s;

`ifdef SENHA_PROGRAMAVEL_EN
    logic [3:0] senha_r;
    assign senha_s = senha_r;
`else
    logic unused_s;
    assign senha_s  = SENHA_PADRAO;
    assign unused_s = ^{bus.gravar, bus.senha_nova};
`endif

    // Absolute distance without wrap, so 15 vs 0 is 15 rather than 1.
    always_comb begin
        diff_s = 4'd0;
        if (senha_s >= bus.tentativa) begin
            diff_s = senha_s - bus.tentativa;
        end else begin
            diff_s = bus.tentativa - senha_s;
        end
    end

    assign falhas_inc_s = falhas_r + 3'd1;

    // Controller FSM with all status outputs held in registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= OCIOSO;
            timer_r     <= 8'd0;
            falhas_r    <= 3'd0;
            aberto_r    <= 1'b0;
            perto_r     <= 1'b0;
            errado_r    <= 1'b0;
            bloqueado_r <= 1'b0;
`ifdef SENHA_PROGRAMAVEL_EN
            senha_r     <= SENHA_PADRAO;
`endif
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (bus.confirmar) begin
                        if (diff_s == 4'd0) begin
                            state_r  <= ABERTO;
                            timer_r  <= TIMER_ABERTO_INI;
                            falhas_r <= 3'd0;
                            aberto_r <= 1'b1;
                            errado_r <= 1'b0;
                            perto_r  <= 1'b0;
                        end else begin
                            errado_r <= 1'b1;
                            perto_r  <= (diff_s <= 4'd3);
                            falhas_r <= falhas_inc_s;
                            if (falhas_inc_s == LIMITE_FALHAS) begin
                                state_r     <= BLOQUEADO;
                                timer_r     <= TIMER_BLOQUEIO_INI;
                                bloqueado_r <= 1'b1;
                            end
                        end
                    end
                end
                ABERTO: begin
`ifdef SENHA_PROGRAMAVEL_EN
                    // Programming is honoured even on the closing edge.
                    if (bus.gravar) begin
                        senha_r <= bus.senha_nova;
                    end
`endif
                    if (bus.fechar || (timer_r == 8'd0)) begin
                        state_r  <= OCIOSO;
                        aberto_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - 8'd1;
                    end
                end
                BLOQUEADO: begin
                    if (timer_r == 8'd0) begin
                        state_r     <= OCIOSO;
                        falhas_r    <= 3'd0;
                        errado_r    <= 1'b0;
                        perto_r     <= 1'b0;
                        bloqueado_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - 8'd1;
                    end
                end
                default: begin
                    state_r     <= OCIOSO;
                    timer_r     <= 8'd0;
                    falhas_r    <= 3'd0;
                    aberto_r    <= 1'b0;
                    perto_r     <= 1'b0;
                    errado_r    <= 1'b0;
                    bloqueado_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aberto    = aberto_r;
    assign bus.perto     = perto_r;
    assign bus.errado    = errado_r;
    assign bus.bloqueado = bloqueado_r;
    assign bus.falhas    = falhas_r;
endmodule

// File: tb/tb_controle_cofre.sv
// Scoreboard bench for controle_cofre: cycle-count reference model feeds an expectation queue.
module tb_controle_cofre;
    localparam logic [3:0] SENHA = 4'd5;
    localparam int MAX_T = 3;
    localparam int T_AB  = 8;
    localparam int T_BL  = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    controle_cofre_if bus ();

    controle_cofre #(
        .SENHA_PADRAO  (SENHA),
        .MAX_TENTATIVAS(MAX_T),
        .TEMPO_ABERTO  (T_AB),
        .TEMPO_BLOQUEIO(T_BL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model: remaining open/lock cycles, failure count, flags, password.
    int         open_left = 0;
    int         lock_left = 0;
    int         fails     = 0;
    bit         m_err     = 1'b0;
    bit         m_perto   = 1'b0;
    logic [3:0] pw        = SENHA;

    logic [7:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int popped   = 0;

    task automatic model(input bit r, input logic [3:0] t, input bit c, input bit f,
                         input bit g, input logic [3:0] n);
        int d;
        if (r) begin
            open_left = 0; lock_left = 0; fails = 0;
            m_err = 1'b0; m_perto = 1'b0; pw = SENHA;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) begin
                fails = 0; m_err = 1'b0; m_perto = 1'b0;
            end
        end else if (open_left > 0) begin
`ifdef SENHA_PROGRAMAVEL_EN
            if (g) pw = n;
`endif
            open_left = f ? 0 : open_left - 1;
        end else if (c) begin
            d = int'(pw) - int'(t);
            if (d < 0) d = -d;
            if (d == 0) begin
                open_left = T_AB; fails = 0; m_err = 1'b0; m_perto = 1'b0;
            end else begin
                m_err = 1'b1; m_perto = (d <= 3); fails++;
                if (fails == MAX_T) lock_left = T_BL;
            end
        end
    endtask

    task automatic step(input bit r, input logic [3:0] t, input bit c, input bit f,
                        input bit g, input logic [3:0] n);
        logic [7:0] e;
        reset = r; bus.tentativa = t; bus.confirmar = c;
        bus.fechar = f; bus.gravar = g; bus.senha_nova = n;
        model(r, t, c, f, g, n);
        e = {open_left > 0, m_perto, m_err, lock_left > 0, 3'(fails)};
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Monitor: one registered result per edge, compared against the oldest expectation.
    initial begin
        logic [7:0] e;
        logic [7:0] got;
        forever begin
            @(posedge clock);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {bus.aberto, bus.perto, bus.errado, bus.bloqueado, bus.falhas};
                checks++;
                popped++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs[%0d] {aberto,perto,errado,bloqueado,falhas}: got %b expected %b",
                             popped, got, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] dist_list[5];
        dist_list = '{4'd8, 4'd9, 4'd2, 4'd1, 4'd15};

        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Correct attempt: open for the full time.
        step(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(10);

        // Near miss, far miss, then lockout with ignored attempts inside it.
        step(1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(2);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (16) step(1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 4'd3);
        step(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(9);

        // Early close in the third open cycle, confirm on that same cycle.
        step(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(2);
        step(1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(2);

        // Program a new password while open, then try old and new.
        step(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9);
        idle(8);
        step(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(9);
        step(1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(9);

        // Reset during lockout, then immediate correct attempt.
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(4);
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(9);

        // Distance boundaries around the default password.
        foreach (dist_list[i]) begin
            step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
            step(1'b0, dist_list[i], 1'b1, 1'b0, 1'b0, 4'd0);
            idle(1);
        end

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [3:0] t;
            t = ($urandom_range(0, 3) == 0) ? pw : 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) == 0, t, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)));
        end
        idle(1);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
